// File: rtl/prg_ray_buf_pkg.sv
// Shared types for the primary-ray buffer: ray payload, screen constants
// and a width helper used by the buffer and its storage array.
package prg_ray_buf_pkg;

    localparam int unsigned SCREEN_W   = 640;
    localparam int unsigned SCREEN_H   = 480;
    localparam int unsigned NUM_PIXELS = SCREEN_W * SCREEN_H;

    localparam int unsigned FLOAT_W    = 32;
    localparam int unsigned PIXEL_ID_W = 19;

    typedef logic [FLOAT_W-1:0] float_t;

    typedef struct packed {
        float_t x;
        float_t y;
        float_t z;
    } vector_t;

    typedef struct packed {
        logic [PIXEL_ID_W-1:0] pixelID;
        vector_t               dir;
    } prg_ray_t;

    // Counter width that never collapses to zero bits for tiny ranges.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/prg_fifo_mem.sv
// Register-array storage for the ray FIFO.
//   clk    : write clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : asynchronous read address
//   rdata  : asynchronous read data (mem[raddr])
// Contents are intentionally not reset.
module prg_fifo_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned W     = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    // Single write port.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/prg_ray_buf.sv
// First-word-fall-through ray buffer between prg_top and the intersection
// pipeline, with early back-pressure and a per-frame delivery counter.
//   clk              : system clock
//   rst              : asynchronous active-low reset
//   rayReady         : prg_data valid this cycle
//   prg_data         : incoming ray
//   int_to_prg_stall : registered back-pressure to prg_top
//   ray_valid        : ray_out holds a valid ray
//   ray_out          : head-of-FIFO ray
//   int_stall        : downstream cannot accept ray_out this cycle
//   frame_done       : pulse on the NUM_RAYS-th delivery (same cycle as deq)
//   occupancy        : current entry count
//   overflow         : sticky, a ray arrived with no space
module prg_ray_buf
    import prg_ray_buf_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned SLACK    = 4,
    parameter int unsigned NUM_RAYS = NUM_PIXELS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rayReady,
    input  prg_ray_t                   prg_data,
    output logic                       int_to_prg_stall,
    output logic                       ray_valid,
    output prg_ray_t                   ray_out,
    input  logic                       int_stall,
    output logic                       frame_done,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       overflow
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned OCC_W  = $clog2(DEPTH + 1);
    localparam int unsigned CNT_W  = clog2_min1(NUM_RAYS);
    localparam int unsigned RAY_W  = $bits(prg_ray_t);
    localparam int unsigned THRESH = DEPTH - SLACK;

    logic [OCC_W-1:0] count_q,   count_d;
    logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
    logic [CNT_W-1:0] ray_cnt_q, ray_cnt_d;
    logic             stall_q,   stall_d;
    logic             overflow_q, overflow_d;

    logic enq_c;
    logic deq_c;
    logic frame_done_c;
    logic [RAY_W-1:0] rdata;

    // A full FIFO still accepts a ray when the head leaves the same cycle.
    always_comb begin
        deq_c        = (count_q != '0) && !int_stall;
        enq_c        = rayReady && ((count_q < OCC_W'(DEPTH)) || deq_c);
        frame_done_c = deq_c && (ray_cnt_q == CNT_W'(NUM_RAYS - 1));
    end

    // Pointer, occupancy, back-pressure and frame bookkeeping.
    always_comb begin
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ray_cnt_d  = ray_cnt_q;
        overflow_d = overflow_q;

        if (enq_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (deq_c) begin
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            ray_cnt_d = frame_done_c ? '0 : ray_cnt_q + CNT_W'(1);
        end

        if (enq_c && !deq_c) begin
            count_d = count_q + OCC_W'(1);
        end else if (!enq_c && deq_c) begin
            count_d = count_q - OCC_W'(1);
        end

        if (rayReady && !enq_c) begin
            overflow_d = 1'b1;
        end

        // Stall is based on next-cycle occupancy so SLACK in-flight rays fit.
        stall_d = (count_d >= OCC_W'(THRESH));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ray_cnt_q  <= '0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ray_cnt_q  <= ray_cnt_d;
            stall_q    <= stall_d;
            overflow_q <= overflow_d;
        end
    end

    prg_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (RAY_W)
    ) u_mem (
        .clk   (clk),
        .we    (enq_c),
        .waddr (wr_ptr_q),
        .wdata (prg_data),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    assign ray_out          = prg_ray_t'(rdata);
    assign ray_valid        = (count_q != '0);
    assign occupancy        = count_q;
    assign int_to_prg_stall = stall_q;
    assign overflow         = overflow_q;
    assign frame_done       = frame_done_c;

endmodule
